// File: rtl/slli_op.sv
// slli_op: registered shift-left-logical-immediate execute unit.
// Rd <= SrcA << Immediate[SHAMT_W-1:0]; upper immediate bits are ignored.
module slli_op #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] Immediate,
  output logic [DATA_WIDTH-1:0] Rd,
  output logic                  out_valid
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] stage [SHAMT_W+1];
  logic [DATA_WIDTH-1:0] rd_d,  rd_q;
  logic                  out_valid_d, out_valid_q;

  // The control-field width and funct7/sign bits are carried only for uniformity.
  logic [OPCODE_LENGTH-1:0]      unused_opcode;
  logic [DATA_WIDTH-SHAMT_W-1:0] unused_imm_hi;
  assign unused_opcode = '0;
  assign unused_imm_hi = Immediate[DATA_WIDTH-1:SHAMT_W];

  assign shamt = Immediate[SHAMT_W-1:0];

  // Log-depth barrel shifter: stage k shifts by 2^k when shamt[k] is set.
  always_comb begin
    stage[0] = SrcA;
    for (int k = 0; k < int'(SHAMT_W); k++) begin
      stage[k+1] = shamt[k] ? (stage[k] << (2**k)) : stage[k];
    end
  end

  // Next-state: capture a result on valid, otherwise hold Rd and drop valid.
  always_comb begin
    rd_d        = rd_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      rd_d = stage[SHAMT_W];
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Rd        = rd_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_slli_op.sv
// tb_slli_op: directed and randomized checks of slli_op against a reference model.
module tb_slli_op;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] SrcA;
  logic [31:0] Immediate;
  logic [31:0] Rd;
  logic        out_valid;

  int vectors;
  int miscompares;

  logic [31:0] m_rd;
  logic        m_valid;

  slli_op #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .SrcA      (SrcA),
    .Immediate (Immediate),
    .Rd        (Rd),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift expressed as multiplication by a power of two, truncated to 32 bits.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] imm);
    logic [63:0] wide;
    wide = 64'(a) * (64'd1 << imm[4:0]);
    return wide[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what Rd/out_valid must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd    <= 32'h0;
      m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) m_rd <= ref_shift(SrcA, Immediate);
    end
  end

  // Cycle-by-cycle compare, mid-cycle away from the active edge.
  always @(negedge clk) begin
    check("model_rd", Rd, m_rd);
    check("model_valid", 32'(out_valid), 32'(m_valid));
  end

  // Present one op on the next edge and check the literal result just after it.
  task automatic op_check(input logic [31:0] a, input logic [31:0] imm,
                          input logic [31:0] exp, input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    SrcA      = a;
    Immediate = imm;
    @(posedge clk);
    #1;
    check(name, Rd, exp);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    SrcA        = 32'h0;
    Immediate   = 32'h0;
    #1;
    check("reset_rd", Rd, 32'h0);
    check("reset_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back basic shifts.
    op_check(32'h0000_0001, 32'h0000_0001, 32'h0000_0002, "shl1");
    op_check(32'h0000_0001, 32'h0000_0004, 32'h0000_0010, "shl4");
    op_check(32'h0000_000F, 32'h0000_0002, 32'h0000_003C, "shl2");
    // Boundaries and ignored upper immediate bits.
    op_check(32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "shamt0");
    op_check(32'h0000_0003, 32'd31,        32'h8000_0000, "shamt31");
    op_check(32'h0000_0001, 32'hFFFF_FFE1, 32'h0000_0002, "imm_hi_ones");
    op_check(32'h0000_0001, 32'h0000_0421, 32'h0000_0002, "imm_funct");
    op_check(32'h8000_0001, 32'hA5A5_A5A4, 32'h0000_0010, "msb_drop");

    // Hold: Rd keeps its value while in_valid is low.
    op_check(32'h0000_000F, 32'h0000_0002, 32'h0000_003C, "hold_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      SrcA      = $urandom;
      Immediate = $urandom;
      @(posedge clk);
      #1;
      check("hold_rd", Rd, 32'h0000_003C);
      check("hold_valid", 32'(out_valid), 32'd0);
    end

    // Mid-cycle asynchronous reset with an op in flight.
    op_check(32'h0000_0001, 32'h0000_0004, 32'h0000_0010, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd", Rd, 32'h0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_rd", Rd, 32'h0);
    check("rst_held_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_rd", Rd, 32'h0);
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // Randomized sweep; the negedge compare process checks every cycle.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      SrcA      = $urandom;
      Immediate = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slli_op.md
# slli_op

Shift-left-logical-immediate execution unit for the RV32I pipeline's execute stage, implementing `slli_operation`. It shifts source operand `SrcA` left by the shift amount carried in the low bits of the decoded immediate. Zeros fill from the right. The result is registered, so it appears one clock after a valid input is presented.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two ≥ 2.
- OPCODE_LENGTH, 4, ALU control field width; kept for interface uniformity with sibling ALU blocks; no logic depends on it.
- SHAMT_W (localparam), $clog2(DATA_WIDTH), shift-amount width (5 for 32-bit).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low; synchronous deassert assumed upstream.
- in_valid  in  1  SrcA/Immediate are valid this cycle.
- SrcA  in  DATA_WIDTH  value to shift (rs1).
- Immediate  in  DATA_WIDTH  sign-extended I-type immediate; only bits [SHAMT_W-1:0] are used.
- Rd  out  DATA_WIDTH  registered shift result.
- out_valid  out  1  Rd holds a fresh result this cycle.

## Operation
- shamt = Immediate[SHAMT_W-1:0], unsigned, range 0..DATA_WIDTH-1.
- Immediate[DATA_WIDTH-1:SHAMT_W] ignored entirely: funct7 bits, sign-extension bits, garbage.
- Result = SrcA << shamt, computed modulo 2^DATA_WIDTH:
  - bits shifted past the MSB are discarded;
  - vacated LSBs are 0;
  - no sign handling, no overflow flag.
- Implemented as a log2(DATA_WIDTH)-stage combinational barrel shifter.
  - Stage k shifts by 2^k when shamt[k]=1, otherwise passes through.
  - Followed by one output register.
- shamt = 0 → Rd = SrcA unchanged.
- shamt = DATA_WIDTH-1 → Rd = {SrcA[0], zeros}.
- in_valid = 1 at a rising edge:
  - Rd ← shift result;
  - out_valid ← 1.
- in_valid = 0 at a rising edge:
  - Rd holds its previous value;
  - out_valid ← 0.
- No back-pressure:
  - a new operation is accepted every cycle;
  - each result is valid for exactly one cycle unless in_valid stays high.
- Inputs with X/Z on ignored Immediate bits must not corrupt Rd.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N; Rd and out_valid valid after edge N (during cycle N+1).
- Throughput: 1 result/cycle.
- Reset (rst_n = 0, any time, independent of clk):
  - Rd = 0 and out_valid = 0 immediately;
  - both held while rst_n is low;
  - any in-flight operation is dropped, not completed.
- First edge after rst_n rises: normal sampling resumes.
- Back-to-back valids: each edge's result replaces the previous one; no stall, no bubble.
- Combinational path is SrcA/Immediate → barrel shifter → Rd D-input. There is no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with in_valid = 1 → Rd = 0x00000000 and out_valid = 0 immediately, without waiting for a clock edge; still 0 after release until the first valid edge.
- Basic shifts, back-to-back with in_valid = 1 on three consecutive edges → each result appears one edge later with out_valid = 1:
  - SrcA = 0x00000001, Immediate = 0x00000001 → Rd = 0x00000002;
  - SrcA = 0x00000001, Immediate = 0x00000004 → Rd = 0x00000010;
  - SrcA = 0x0000000F, Immediate = 0x00000002 → Rd = 0x0000003C.
- Boundaries:
  - SrcA = 0xDEADBEEF, Immediate = 0 → Rd = 0xDEADBEEF;
  - SrcA = 0x00000003, Immediate = 31 → Rd = 0x80000000.
- Upper immediate bits ignored:
  - SrcA = 0x00000001, Immediate = 0xFFFFFFE1 → Rd = 0x00000002;
  - SrcA = 0x00000001, Immediate = 0x00000421 → Rd = 0x00000002.
- Hold: one valid op (SrcA = 0x0000000F, Immediate = 2) then in_valid = 0 for 3 cycles → Rd stays 0x0000003C, out_valid = 0 after the first cycle.
- Randomized sweep of 1000 ops with random in_valid → Rd matches the reference model (SrcA << Immediate[4:0]) & 0xFFFFFFFF one cycle after each valid.
